ram_dual_bist: RTL and testbench
================================

RAM_DUAL_BIST -- requirements
Module: ram_dual_bist

Interface
REQ-001 SHALL have parameters: DW, default 8, data width; AW, default 3, address width (8 words).
REQ-002 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-003 SHALL have ports: rst_n  in  1  synchronous reset, active-low.
REQ-004 SHALL have ports: start  in  1  begin test, sampled only in IDLE or DONE.
REQ-005 SHALL have ports: busy  out  1  test running; done  out  1  test finished (level); pass  out  1  no mismatch found.
REQ-006 SHALL have ports: fail_addr  out  AW  address of first mismatch; fail_data  out  DW  data read there; fail_port  out  1  0=A, 1=B.
REQ-007 SHALL have RAM-side ports: din_a, din_b  out  DW; addr_a, addr_b  out  AW; we  out  1  shared write enable; dout_a, dout_b  in  DW  RAM read data.

Function
REQ-008 SHALL drive a dual-port synchronous RAM whose dout_x reflects addr_x one clk after that address is sampled.
REQ-009 SHALL register all outputs.
REQ-010 SHALL implement states IDLE, WRITE, READ, FLUSH, DONE.
REQ-011 SHALL go IDLE->WRITE, or DONE->WRITE, on start=1, clearing done, pass, fail_* and pass counter p.
REQ-012 SHALL run two passes, p=0 with base 8'h55 and p=1 with base 8'hAA; word i pattern = base XOR i (zero-extended).
REQ-013 WRITE, 4 cycles, k=0..3: we=1, addr_a=2k, din_a=pat(2k), addr_b=2k+1, din_b=pat(2k+1); A writes even words, B writes odd words; port addresses never equal.
REQ-014 READ, 4 cycles, k=0..3: we=0, addr_a=2k+1, addr_b=2k; cross-port readback, even via B, odd via A.
REQ-015 SHALL compare dout_a/dout_b against expected one cycle after each READ address, with expected pipelined alongside.
REQ-016 FLUSH, 1 cycle: we=0; compares the k=3 read.
REQ-017 After FLUSH: p=0 -> WRITE with p=1; p=1 -> DONE.
REQ-018 Each pass SHALL take 9 cycles; busy=1 for exactly 18 cycles on a clean run.
REQ-019 On first mismatch SHALL latch fail_addr/fail_data/fail_port, abort to DONE next edge, and set pass=0.
REQ-020 When both ports mismatch in the same compare cycle, SHALL report port B (the even, lower address).
REQ-021 DONE SHALL hold done=1, busy=0, we=0, and pass=1 only if no mismatch occurred, until start or reset.
REQ-022 SHALL ignore start while busy.
REQ-023 we SHALL be 1 only in WRITE.

Reset
REQ-024 rst_n=0 sampled at an edge SHALL force IDLE, p=0, and outputs we, busy, done, pass, fail_*, addr_*, din_* all to 0, from any state.
REQ-025 Reset mid-WRITE SHALL produce no further writes: we=0 from the reset edge on.

Structure
REQ-026 Package ram_bist_pkg SHALL hold the state enum, PAT0=8'h55, PAT1=8'hAA, NPASS=2, and NPAIR=4.
REQ-027 A sub-module ram_bist_chk SHALL hold the compare, priority select, and first-fail latch; sequencing stays in ram_dual_bist.

Verification
REQ-028 Run with an ideal RAM model; pulse start -> busy high 18 cycles, then done=1, pass=1, busy=0.
REQ-029 Check WRITE pass 0 -> (addr_a,din_a,addr_b,din_b) = (0,55,1,54), (2,57,3,56), (4,51,5,50), (6,53,7,52) hex.
REQ-030 Stick word 5 bit0 at 0 -> pass 0 is clean (0x50); pass 1 gives fail_addr=5, fail_data=0xAE, fail_port=0, pass=0, done=1.
REQ-031 Corrupt words 2 and 3 together -> fail_addr=2, fail_port=1.
REQ-032 Assert rst_n=0 in WRITE cycle k=1 -> next edge we=0, busy=0, IDLE; RAM words 2..7 untouched.
REQ-033 Pulse start mid-run -> ignored and timing unchanged; pulse start in DONE -> done/pass cleared, new 18-cycle run.

Source files
------------

// File: rtl/ram_bist_pkg.sv
// rtl/ram_bist_pkg.sv - shared types and constants for the dual-port RAM BIST
// Holds the sequencer state enum, the two pass base patterns, the pass and
// pair counts, and the helper that selects a pass base pattern.
package ram_bist_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_FLUSH,
        S_DONE
    } state_t;

    localparam logic [7:0] PAT0  = 8'h55;
    localparam logic [7:0] PAT1  = 8'hAA;
    localparam int         NPASS = 2;
    localparam int         NPAIR = 4;
    localparam int         KW    = $clog2(NPAIR);

    function automatic logic [7:0] pass_base(input logic p);
        return p ? PAT1 : PAT0;
    endfunction

endpackage

// File: rtl/ram_dual_bist_if.sv
// rtl/ram_dual_bist_if.sv - RAM-side bus between the BIST engine and a dual-port RAM
// Signals: we (shared write enable), addr_a/addr_b, din_a/din_b (write data),
// dout_a/dout_b (synchronous read data, one clk after the address).
// master: BIST engine side; slave: RAM side.
interface ram_dual_bist_if #(
    parameter int DW = 8,
    parameter int AW = 3
);
    logic          we;
    logic [AW-1:0] addr_a;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] din_a;
    logic [DW-1:0] din_b;
    logic [DW-1:0] dout_a;
    logic [DW-1:0] dout_b;

    modport master (
        output we, addr_a, addr_b, din_a, din_b,
        input  dout_a, dout_b
    );

    modport slave (
        input  we, addr_a, addr_b, din_a, din_b,
        output dout_a, dout_b
    );
endinterface

// File: rtl/ram_bist_chk.sv
// rtl/ram_bist_chk.sv - readback compare, port priority and first-fail latch
// Ports: clk, rst_n (sync, active-low), clear (start of a new test),
// rd_en/rd_addr_*/rd_exp_* (read issued this cycle and its expected data),
// dout_a/dout_b (RAM data), mismatch (comb, current compare failed),
// fail_addr/fail_data/fail_port (registered first failure).
module ram_bist_chk #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr_a,
    input  logic [AW-1:0] rd_addr_b,
    input  logic [DW-1:0] rd_exp_a,
    input  logic [DW-1:0] rd_exp_b,
    input  logic [DW-1:0] dout_a,
    input  logic [DW-1:0] dout_b,
    output logic          mismatch,
    output logic [AW-1:0] fail_addr,
    output logic [DW-1:0] fail_data,
    output logic          fail_port
);

    // Expected values travel one stage behind the issued address so they line
    // up with the RAM's one-cycle read latency.
    logic          cmp_valid;
    logic [AW-1:0] cmp_addr_a;
    logic [AW-1:0] cmp_addr_b;
    logic [DW-1:0] cmp_exp_a;
    logic [DW-1:0] cmp_exp_b;
    logic          failed;
    logic          miss_a;
    logic          miss_b;

    assign miss_a   = cmp_valid && (dout_a != cmp_exp_a);
    assign miss_b   = cmp_valid && (dout_b != cmp_exp_b);
    assign mismatch = miss_a || miss_b;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cmp_valid  <= 1'b0;
            cmp_addr_a <= '0;
            cmp_addr_b <= '0;
            cmp_exp_a  <= '0;
            cmp_exp_b  <= '0;
            failed     <= 1'b0;
            fail_addr  <= '0;
            fail_data  <= '0;
            fail_port  <= 1'b0;
        end else begin
            // A mismatch aborts the run, so the read still in flight is dropped.
            cmp_valid  <= rd_en && !mismatch;
            cmp_addr_a <= rd_addr_a;
            cmp_addr_b <= rd_addr_b;
            cmp_exp_a  <= rd_exp_a;
            cmp_exp_b  <= rd_exp_b;
            if (mismatch && !failed) begin
                failed <= 1'b1;
                // Port B carries the even (lower) address of the pair, so it wins.
                if (miss_b) begin
                    fail_addr <= cmp_addr_b;
                    fail_data <= dout_b;
                    fail_port <= 1'b1;
                end else begin
                    fail_addr <= cmp_addr_a;
                    fail_data <= dout_a;
                    fail_port <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/ram_dual_bist.sv
// rtl/ram_dual_bist.sv - two-pass cross-port BIST sequencer for a dual-port RAM
// Ports: clk, rst_n (sync, active-low), start (accepted in IDLE/DONE only),
// busy/done/pass status, fail_addr/fail_data/fail_port first failure,
// ram (master side of the RAM bus: we, addr_*, din_*, dout_*).
// Each pass writes base^i (A even words, B odd words), then reads back
// crosswise (A odd, B even), then flushes the last compare.
module ram_dual_bist
    import ram_bist_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [AW-1:0]   fail_addr,
    output logic [DW-1:0]   fail_data,
    output logic            fail_port,
    ram_dual_bist_if.master ram
);

    state_t          state, state_n;
    logic [KW-1:0]   k, k_n;
    logic            p, p_n;

    logic            we_q, we_n;
    logic [AW-1:0]   addr_a_q, addr_a_n, addr_b_q, addr_b_n;
    logic [DW-1:0]   din_a_q, din_a_n, din_b_q, din_b_n;
    logic            busy_n, done_n, pass_n;

    logic            emit_wr, emit_rd, p_e, clear;
    logic [KW-1:0]   k_e;
    logic [7:0]      base_e;
    logic [AW-1:0]   even_e, odd_e;

    logic            mismatch;
    logic [DW-1:0]   cur_base;

    assign cur_base = DW'(pass_base(p));

    // Outputs always show the step named by state/k; the comb block therefore
    // prepares the bus values of the step being entered (p_e, k_e).
    always_comb begin
        state_n = state;
        k_n     = k;
        p_n     = p;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        pass_n  = 1'b0;
        emit_wr = 1'b0;
        emit_rd = 1'b0;
        p_e     = p;
        k_e     = '0;
        clear   = 1'b0;

        unique case (state)
            S_IDLE, S_DONE: begin
                done_n = (state == S_DONE);
                pass_n = pass;
                if (start) begin
                    state_n = S_WRITE;
                    k_n     = '0;
                    p_n     = 1'b0;
                    p_e     = 1'b0;
                    emit_wr = 1'b1;
                    busy_n  = 1'b1;
                    done_n  = 1'b0;
                    pass_n  = 1'b0;
                    clear   = 1'b1;
                end
            end
            S_WRITE: begin
                busy_n = 1'b1;
                if (k == KW'(NPAIR - 1)) begin
                    state_n = S_READ;
                    k_n     = '0;
                    emit_rd = 1'b1;
                end else begin
                    k_n     = k + KW'(1);
                    k_e     = k + KW'(1);
                    emit_wr = 1'b1;
                end
            end
            S_READ: begin
                if (mismatch) begin
                    state_n = S_DONE;
                    done_n  = 1'b1;
                end else begin
                    busy_n = 1'b1;
                    if (k == KW'(NPAIR - 1)) begin
                        state_n = S_FLUSH;
                    end else begin
                        k_n     = k + KW'(1);
                        k_e     = k + KW'(1);
                        emit_rd = 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                if (mismatch) begin
                    state_n = S_DONE;
                    done_n  = 1'b1;
                end else if (p == 1'(NPASS - 1)) begin
                    state_n = S_DONE;
                    done_n  = 1'b1;
                    pass_n  = 1'b1;
                end else begin
                    state_n = S_WRITE;
                    p_n     = 1'b1;
                    k_n     = '0;
                    p_e     = 1'b1;
                    emit_wr = 1'b1;
                    busy_n  = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase

        base_e   = pass_base(p_e);
        even_e   = AW'({k_e, 1'b0});
        odd_e    = AW'({k_e, 1'b1});
        we_n     = 1'b0;
        addr_a_n = '0;
        addr_b_n = '0;
        din_a_n  = '0;
        din_b_n  = '0;
        if (emit_wr) begin
            we_n     = 1'b1;
            addr_a_n = even_e;
            din_a_n  = DW'(base_e) ^ DW'(even_e);
            addr_b_n = odd_e;
            din_b_n  = DW'(base_e) ^ DW'(odd_e);
        end
        if (emit_rd) begin
            addr_a_n = odd_e;
            addr_b_n = even_e;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            k        <= '0;
            p        <= 1'b0;
            we_q     <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            din_a_q  <= '0;
            din_b_q  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
        end else begin
            state    <= state_n;
            k        <= k_n;
            p        <= p_n;
            we_q     <= we_n;
            addr_a_q <= addr_a_n;
            addr_b_q <= addr_b_n;
            din_a_q  <= din_a_n;
            din_b_q  <= din_b_n;
            busy     <= busy_n;
            done     <= done_n;
            pass     <= pass_n;
        end
    end

    assign ram.we     = we_q;
    assign ram.addr_a = addr_a_q;
    assign ram.addr_b = addr_b_q;
    assign ram.din_a  = din_a_q;
    assign ram.din_b  = din_b_q;

    ram_bist_chk #(.DW(DW), .AW(AW)) u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .rd_en     (state == S_READ),
        .rd_addr_a (addr_a_q),
        .rd_addr_b (addr_b_q),
        .rd_exp_a  (cur_base ^ DW'(addr_a_q)),
        .rd_exp_b  (cur_base ^ DW'(addr_b_q)),
        .dout_a    (ram.dout_a),
        .dout_b    (ram.dout_b),
        .mismatch  (mismatch),
        .fail_addr (fail_addr),
        .fail_data (fail_data),
        .fail_port (fail_port)
    );

endmodule

// File: tb/tb_ram_dual_bist.sv
// tb/tb_ram_dual_bist.sv - directed self-checking bench for ram_dual_bist
module tb_ram_dual_bist;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] fail_addr;
    logic [7:0] fail_data;
    logic       fail_port;

    int n_checks = 0;
    int n_pass   = 0;

    bit         stuck5    = 1'b0;
    bit         corrupt23 = 1'b0;
    bit         clr_mem   = 1'b0;
    logic [7:0] mem [8];

    int   ncyc;
    logic d0, p0;

    logic [31:0] wr_tab [4] = '{32'h00550154, 32'h02570356, 32'h04510550, 32'h06530752};

    ram_dual_bist_if #(.DW(8), .AW(3)) ram_if ();

    ram_dual_bist #(.DW(8), .AW(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_addr (fail_addr),
        .fail_data (fail_data),
        .fail_port (fail_port),
        .ram       (ram_if)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] fault(input logic [2:0] a, input logic [7:0] d);
        logic [7:0] r;
        r = d;
        if (stuck5 && a == 3'd5) r[0] = 1'b0;
        if (corrupt23 && (a == 3'd2 || a == 3'd3)) r = r ^ 8'hFF;
        return r;
    endfunction

    // Ideal synchronous dual-port RAM with optional read-side faults.
    always @(posedge clk) begin
        if (clr_mem) begin
            for (int i = 0; i < 8; i++) mem[i] <= 8'h00;
        end else if (ram_if.we) begin
            mem[ram_if.addr_a] <= ram_if.din_a;
            mem[ram_if.addr_b] <= ram_if.din_b;
        end
        ram_if.dout_a <= fault(ram_if.addr_a, mem[ram_if.addr_a]);
        ram_if.dout_b <= fault(ram_if.addr_b, mem[ram_if.addr_b]);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic run_test(input int pulse_at, input bit chk_wr);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ncyc  = 0;
        d0    = done;
        p0    = pass;
        for (int i = 0; i < 60; i++) begin
            if (!busy) break;
            ncyc++;
            if (chk_wr && i < 4)
                check($sformatf("wr_k%0d", i),
                      {5'b0, ram_if.addr_a, ram_if.din_a, 5'b0, ram_if.addr_b, ram_if.din_b},
                      wr_tab[i]);
            if (chk_wr && i == 4)
                check("rd_k0", 32'({ram_if.we, ram_if.addr_a, ram_if.addr_b}), 32'h08);
            start = (i == pulse_at);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_done",      32'(done),      32'd0);
        check("rst_pass",      32'(pass),      32'd0);
        check("rst_we",        32'(ram_if.we), 32'd0);
        check("rst_fail_addr", 32'(fail_addr), 32'd0);
        check("rst_fail_data", 32'(fail_data), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Clean run with write vector and first read checks
        run_test(-1, 1'b1);
        check("clean_cycles", 32'(ncyc),      32'd18);
        check("clean_done",   32'(done),      32'd1);
        check("clean_pass",   32'(pass),      32'd1);
        check("clean_busy",   32'(busy),      32'd0);
        check("clean_we",     32'(ram_if.we), 32'd0);
        check("clean_mem5",   32'(mem[5]),    32'hAF);

        // Restart from DONE with a start pulse in the middle of the run
        run_test(5, 1'b0);
        check("restart_done_clr", 32'(d0),   32'd0);
        check("restart_pass_clr", 32'(p0),   32'd0);
        check("restart_cycles",   32'(ncyc), 32'd18);
        check("restart_pass",     32'(pass), 32'd1);

        // Word 5 bit0 stuck at 0: clean in pass 0, fails in pass 1 on port A
        stuck5 = 1'b1;
        run_test(-1, 1'b0);
        stuck5 = 1'b0;
        check("stuck_cycles",    32'(ncyc),      32'd17);
        check("stuck_fail_addr", 32'(fail_addr), 32'd5);
        check("stuck_fail_data", 32'(fail_data), 32'hAE);
        check("stuck_fail_port", 32'(fail_port), 32'd0);
        check("stuck_pass",      32'(pass),      32'd0);
        check("stuck_done",      32'(done),      32'd1);

        // Words 2 and 3 both bad in one compare: port B reported
        corrupt23 = 1'b1;
        run_test(-1, 1'b0);
        corrupt23 = 1'b0;
        check("dual_cycles",    32'(ncyc),      32'd7);
        check("dual_fail_addr", 32'(fail_addr), 32'd2);
        check("dual_fail_data", 32'(fail_data), 32'hA8);
        check("dual_fail_port", 32'(fail_port), 32'd1);
        check("dual_pass",      32'(pass),      32'd0);
        check("dual_done",      32'(done),      32'd1);

        // Reset sampled at the edge that would begin WRITE k=1
        clr_mem = 1'b1;
        @(negedge clk);
        clr_mem = 1'b0;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        check("rstw_we_k0", 32'(ram_if.we), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rstw_we",        32'(ram_if.we), 32'd0);
        check("rstw_busy",      32'(busy),      32'd0);
        check("rstw_fail_addr", 32'(fail_addr), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rstw_idle_busy", 32'(busy), 32'd0);
        check("rstw_idle_done", 32'(done), 32'd0);
        check("rstw_mem0", 32'(mem[0]), 32'h55);
        check("rstw_mem1", 32'(mem[1]), 32'h54);
        for (int i = 2; i < 8; i++)
            check($sformatf("rstw_mem%0d", i), 32'(mem[i]), 32'h00);

        // Fresh run from IDLE after the reset
        run_test(-1, 1'b0);
        check("final_cycles", 32'(ncyc), 32'd18);
        check("final_pass",   32'(pass), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
